mem_bus_ctrl: RTL



---
 rtl/mem_bus_ctrl_if.sv | 29 ++
 rtl/mem_bus_ctrl.sv | 135 +++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl_if.sv
// rtl/mem_bus_ctrl_if.sv - CPU request/response and memory control signals of the bus controller
interface mem_bus_ctrl_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_load;
  logic              mem_store;
  logic              mem_drive_en;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata,
    output mem_addr, mem_load, mem_store, mem_drive_en
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata,
    input  mem_addr, mem_load, mem_store, mem_drive_en
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// rtl/mem_bus_ctrl.sv - single-port memory bus controller with fixed access time and bus turnaround
module mem_bus_ctrl #(
  parameter int WAIT_CYCLES = 3,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_bus_ctrl_if.slave     bus,
  inout  wire  [DATA_W-1:0] mem_data
);
  localparam int              CW    = 4;
  localparam logic [CW-1:0]   W_CNT = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0]   C_ONE = CW'(1);

  typedef enum logic [2:0] {S_IDLE, S_TURN, S_READ, S_WRITE, S_RESP} state_t;

  state_t            r_state, w_state_nx;
  logic [CW-1:0]     r_cnt, w_cnt_nx;
  logic [CW-1:0]     r_turn_cnt, w_turn_nx;
  logic [ADDR_W-1:0] r_addr, w_addr_nx;
  logic [DATA_W-1:0] r_wdata, w_wdata_nx;
  logic [DATA_W-1:0] r_rdata, w_rdata_nx;
  logic              r_ready, w_ready_nx;
  logic              r_load, w_load_nx;
  logic              r_store, w_store_nx;
  logic              r_drive, w_drive_nx;
  logic              r_resp, w_resp_nx;
  logic              w_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_turn_cnt <= W_CNT;  // memory may still be driving a read result
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
      r_ready    <= 1'b0;
      r_load     <= 1'b0;
      r_store    <= 1'b0;
      r_drive    <= 1'b0;
      r_resp     <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_turn_cnt <= w_turn_nx;
      r_addr     <= w_addr_nx;
      r_wdata    <= w_wdata_nx;
      r_rdata    <= w_rdata_nx;
      r_ready    <= w_ready_nx;
      r_load     <= w_load_nx;
      r_store    <= w_store_nx;
      r_drive    <= w_drive_nx;
      r_resp     <= w_resp_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_turn_nx  = (r_turn_cnt != '0) ? (r_turn_cnt - C_ONE) : r_turn_cnt;
    w_addr_nx  = r_addr;
    w_wdata_nx = r_wdata;
    w_rdata_nx = r_rdata;
    w_load_nx  = r_load;
    w_store_nx = 1'b0;
    w_drive_nx = r_drive;
    w_resp_nx  = 1'b0;
    w_accept   = bus.req_valid & r_ready;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_addr_nx  = bus.req_addr;
          w_wdata_nx = bus.req_wdata;
          if (!bus.req_write) begin
            w_state_nx = S_READ;
            w_load_nx  = 1'b1;
            w_cnt_nx   = W_CNT - C_ONE;
          end else if (r_turn_cnt == '0) begin
            w_state_nx = S_WRITE;
            w_store_nx = 1'b1;
            w_drive_nx = 1'b1;
            w_cnt_nx   = W_CNT;
          end else begin
            w_state_nx = S_TURN;
          end
        end
      end
      S_TURN: begin
        if (r_turn_cnt == '0) begin
          w_state_nx = S_WRITE;
          w_store_nx = 1'b1;
          w_drive_nx = 1'b1;
          w_cnt_nx   = W_CNT;
        end
      end
      S_READ: begin
        w_turn_nx = W_CNT;
        if (r_cnt == '0) begin
          w_state_nx = S_RESP;
          w_load_nx  = 1'b0;
          w_rdata_nx = mem_data;
          w_resp_nx  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - C_ONE;
        end
      end
      S_WRITE: begin
        // strobe lasts one cycle; data and address stay for the delayed write
        if (r_cnt == '0) begin
          w_state_nx = S_RESP;
          w_drive_nx = 1'b0;
          w_resp_nx  = 1'b1;
        end else begin
          w_cnt_nx = r_cnt - C_ONE;
        end
      end
      S_RESP:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase

    w_ready_nx = (w_state_nx == S_IDLE);
  end

  assign bus.req_ready    = r_ready;
  assign bus.resp_valid   = r_resp;
  assign bus.resp_rdata   = r_rdata;
  assign bus.mem_addr     = r_addr;
  assign bus.mem_load     = r_load;
  assign bus.mem_store    = r_store;
  assign bus.mem_drive_en = r_drive;
  assign mem_data         = r_drive ? r_wdata : {DATA_W{1'bz}};
endmodule
